fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage; Wishbone master that sits directly upstream of the instruction ROM slave.
- Generates sequential word addresses and runs single read transactions.
- Buffers returned words, each tagged with its PC, in a small FIFO for the decoder.
- Supports redirect (branch/jump) with flush, and reports bus errors as faulting entries.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, number of instruction entries buffered (power of two, ≥2).
- Data/address width: codebase `DAT_WIDTH` (32); word stride `DAT_WIDTH/8` = 4 bytes.

Ports:
- rst_i  in  1  synchronous active-high reset.
- clk_i  in  1  single clock; all logic on posedge.
- fetch_adr_o  out  32  Wishbone address; bits [1:0] always 0.
- fetch_dat_i  in  32  Wishbone read data.
- fetch_dat_o  out  32  Wishbone write data; constant 0.
- fetch_we_o  out  1  Wishbone write enable; constant 0.
- fetch_stb_o  out  1  Wishbone strobe.
- fetch_cyc_o  out  1  Wishbone cycle; equal to fetch_stb_o.
- fetch_ack_i  in  1  slave acknowledge.
- fetch_err_i  in  1  slave error.
- instr_o  out  32  FIFO head instruction word.
- instr_pc_o  out  32  address of instr_o.
- instr_fault_o  out  1  head entry is a bus-error entry; instr_o is 0.
- instr_valid_o  out  1  FIFO not empty.
- instr_ready_i  in  1  consumer pops head when valid && ready.
- redirect_i  in  1  one-cycle pulse: flush and restart fetch.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored.

Behaviour:
- Reset (synchronous, rst_i high at posedge):
  - state=IDLE, stb/cyc=0, FIFO empty, instr_valid_o=0, instr_fault_o=0, instr_o=0, instr_pc_o=0.
  - fetch_pc=RESET_PC, stale=0.
  - Reset mid-transaction drops stb the next cycle; the in-flight result is never pushed.
- All Wishbone outputs are registered.
- States:
  - IDLE: if not halted and FIFO count (after this cycle's pop) < FIFO_DEPTH → REQ. Drive adr_o=fetch_pc, stb=cyc=1.
  - REQ: hold adr/stb stable until ack_i or err_i sampled high.
    - On ack: push {dat_i, adr_o, fault=0} unless stale; fetch_pc += 4 (wraps mod 2^32) unless stale; → GAP; stb=0.
    - On err: push {0, adr_o, fault=1} unless stale; set halted unless stale; → GAP; stb=0.
  - GAP: stb held low exactly one cycle so the slave returns to idle; clear stale; → IDLE.
- Issue timing: a request is issued the cycle after IDLE. With a slave that acks the cycle after stb, back-to-back fetches issue every 3 cycles:
  - C1: stb high.
  - C2: ack high; push at the end of C2.
  - C3: GAP, instr_valid_o=1.
  - C4: next stb.
- At most one transaction outstanding. FIFO can never overflow: issue is gated on free space and the push lands before the next issue decision.
- Simultaneous push and pop in one cycle is allowed; count unchanged.
- Redirect (redirect_i high at posedge):
  - FIFO flushed that edge; instr_valid_o=0 the next cycle.
  - fetch_pc=redirect_pc_i & ~3; halted cleared.
  - If in REQ, set stale: the transaction completes normally, its data is discarded, then GAP → IDLE → new address.
  - If in GAP or IDLE, the next issue uses the new PC.
  - A pop in the same cycle is ignored.
  - Redirect has priority over a simultaneous push: the push is dropped.
- Halted: no further issue until redirect or reset. The fault entry remains poppable.
- Slave error with stb held: the error is sampled once; stb drops in GAP regardless.
- Outputs instr_o, instr_pc_o and instr_fault_o reflect the FIFO head directly. Their value is don't-care when instr_valid_o=0, but they must be driven (no X).

Test Plan:
1. Reset release; ROM words 0x11,0x22,0x33 at 0,4,8; ready=1 → stb at adr 0,4,8 spaced 3 cycles; instr_o/instr_pc_o = (0x11,0),(0x22,4),(0x33,8); stb low for 1 cycle between requests.
2. ready=0 → exactly 4 fetches (adr 0,4,8,C), then stb stays 0. Raise ready for 1 cycle → one pop, then one new fetch at adr 0x10.
3. Redirect to 0x42 while in REQ for adr 4 → the adr-4 word is not delivered; next request adr=0x40; first delivered entry has pc 0x40. FIFO empty the cycle after redirect.
4. Slave err at adr 0x1FC (past end of code) → entry pc=0x1FC, fault=1, instr_o=0; no further stb. Redirect to 0 → fetching resumes at 0, fault=0.
5. fetch_pc=0xFFFF_FFFC via redirect, ack → next adr 0x0000_0000 (wrap).
6. Assert rst_i while stb high → stb=0 and instr_valid_o=0 next cycle; restart at RESET_PC with the stale data not delivered.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: Wishbone read master feeding a small FIFO of
// {instruction, pc, fault} entries, with redirect/flush and bus-error halting.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        rst_i,
   input  logic        clk_i,
   output logic [31:0] fetch_adr_o,
   input  logic [31:0] fetch_dat_i,
   output logic [31:0] fetch_dat_o,
   output logic        fetch_we_o,
   output logic        fetch_stb_o,
   output logic        fetch_cyc_o,
   input  logic        fetch_ack_i,
   input  logic        fetch_err_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_fault_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);

   localparam int DAT_WIDTH = 32;
   localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW        = PW + 1;
   localparam logic [DAT_WIDTH-1:0] STRIDE   = DAT_WIDTH'(DAT_WIDTH / 8);
   localparam logic [DAT_WIDTH-1:0] ALIGN_MK = ~DAT_WIDTH'(3);
   localparam logic [CW-1:0]        DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t                 state;
   logic [DAT_WIDTH-1:0]   fetch_pc;
   logic [DAT_WIDTH-1:0]   adr;
   logic                   stb;
   logic                   stale;
   logic                   halted;

   logic [DAT_WIDTH-1:0]   mem_dat [FIFO_DEPTH];
   logic [DAT_WIDTH-1:0]   mem_pc  [FIFO_DEPTH];
   logic                   mem_flt [FIFO_DEPTH];
   logic [PW-1:0]          rd_ptr;
   logic [PW-1:0]          wr_ptr;
   logic [CW-1:0]          count;

   logic                   done;
   logic                   push;
   logic                   pop;
   logic [CW-1:0]          count_after_pop;
   logic                   can_issue;

   assign done            = (state == REQ) && (fetch_ack_i || fetch_err_i);
   assign push            = done && !stale && !redirect_i && !rst_i;
   assign pop             = (count != '0) && instr_ready_i && !redirect_i;
   assign count_after_pop = count - CW'(pop);
   // A redirect this cycle must not launch a fetch from the old PC.
   assign can_issue       = !halted && !redirect_i && (count_after_pop < DEPTH_C);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         stb      <= 1'b0;
         adr      <= '0;
         stale    <= 1'b0;
         halted   <= 1'b0;
         fetch_pc <= RESET_PC & ALIGN_MK;
      end else begin
         if (redirect_i) begin
            fetch_pc <= redirect_pc_i & ALIGN_MK;
            halted   <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (can_issue) begin
                  state <= REQ;
                  stb   <= 1'b1;
                  adr   <= fetch_pc;
               end
            end
            REQ: begin
               if (done) begin
                  state <= GAP;
                  stb   <= 1'b0;
                  if (!stale && !redirect_i) begin
                     if (fetch_err_i) halted   <= 1'b1;
                     else             fetch_pc <= fetch_pc + STRIDE;
                  end
               end else if (redirect_i) begin
                  stale <= 1'b1;
               end
            end
            GAP: begin
               // Strobe has been low for this one cycle; next issue may start now.
               stale <= 1'b0;
               if (can_issue) begin
                  state <= REQ;
                  stb   <= 1'b1;
                  adr   <= fetch_pc;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               stb   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || redirect_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_dat[wr_ptr] <= fetch_err_i ? '0 : fetch_dat_i;
         mem_pc[wr_ptr]  <= adr;
         mem_flt[wr_ptr] <= fetch_err_i;
      end
   end

   assign fetch_adr_o   = adr;
   assign fetch_dat_o   = '0;
   assign fetch_we_o    = 1'b0;
   assign fetch_stb_o   = stb;
   assign fetch_cyc_o   = stb;

   // Head fields are forced to zero while empty so they are never undefined.
   assign instr_valid_o = (count != '0);
   assign instr_o       = instr_valid_o ? mem_dat[rd_ptr] : '0;
   assign instr_pc_o    = instr_valid_o ? mem_pc[rd_ptr]  : '0;
   assign instr_fault_o = instr_valid_o ? mem_flt[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered Wishbone ROM slave model, per-cycle vector
// tables for sequential fetch / backpressure, and directed corner sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_adr;
   logic [31:0] fetch_dat_in;
   logic [31:0] fetch_dat_out;
   logic        fetch_we;
   logic        fetch_stb;
   logic        fetch_cyc;
   logic        fetch_ack = 1'b0;
   logic        fetch_err = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_fault;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .rst_i         (rst),
      .clk_i         (clk),
      .fetch_adr_o   (fetch_adr),
      .fetch_dat_i   (fetch_dat_in),
      .fetch_dat_o   (fetch_dat_out),
      .fetch_we_o    (fetch_we),
      .fetch_stb_o   (fetch_stb),
      .fetch_cyc_o   (fetch_cyc),
      .fetch_ack_i   (fetch_ack),
      .fetch_err_i   (fetch_err),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc),
      .instr_fault_o (instr_fault),
      .instr_valid_o (instr_valid),
      .instr_ready_i (instr_ready),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0011;
         32'h4:   return 32'h0000_0022;
         32'h8:   return 32'h0000_0033;
         default: return a ^ 32'hC0DE_0000;
      endcase
   endfunction

   // Slave answers one cycle after it sees the strobe; 0x1FC lies past the code.
   always @(posedge clk) begin
      if (fetch_stb && !fetch_ack && !fetch_err && !stall) begin
         fetch_ack    <= (fetch_adr != 32'h1FC);
         fetch_err    <= (fetch_adr == 32'h1FC);
         fetch_dat_in <= (fetch_adr == 32'h1FC) ? 32'h0 : rom_word(fetch_adr);
      end else begin
         fetch_ack <= 1'b0;
         fetch_err <= 1'b0;
      end
   end

   typedef struct {
      logic        rdy;
      logic        stb;
      logic [31:0] adr;
      logic        vld;
      logic [31:0] ins;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rdy, input logic stb, input logic [31:0] adr,
                               input logic vld, input logic [31:0] ins, input logic [31:0] pc);
      vec_t v;
      v.rdy = rdy; v.stb = stb; v.adr = adr; v.vld = vld; v.ins = ins; v.pc = pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting, got none expected event", name);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      @(negedge clk);
      redirect    = 1'b0;
   endtask

   // Returns at the negedge of the first cycle of the next strobe.
   task automatic wait_stb(input logic [31:0] exp_adr, input string name);
      int n = 0;
      while (fetch_stb === 1'b1 && n < 50) begin @(negedge clk); n++; end
      while (fetch_stb !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout(name);
      else         chk(name, fetch_adr, exp_adr);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (instr_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout(name);
   endtask

   task automatic run_vecs(input string name);
      foreach (vecs[i]) begin
         chk($sformatf("%s c%0d stb", name, i), {31'b0, fetch_stb}, {31'b0, vecs[i].stb});
         chk($sformatf("%s c%0d cyc", name, i), {31'b0, fetch_cyc}, {31'b0, vecs[i].stb});
         if (vecs[i].stb)
            chk($sformatf("%s c%0d adr", name, i), fetch_adr, vecs[i].adr);
         chk($sformatf("%s c%0d valid", name, i), {31'b0, instr_valid}, {31'b0, vecs[i].vld});
         if (vecs[i].vld) begin
            chk($sformatf("%s c%0d instr", name, i), instr, vecs[i].ins);
            chk($sformatf("%s c%0d pc", name, i), instr_pc, vecs[i].pc);
            chk($sformatf("%s c%0d fault", name, i), {31'b0, instr_fault}, 32'h0);
         end
         instr_ready = vecs[i].rdy;
         @(negedge clk);
      end
      vecs.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;

      // Sequential fetch, consumer always ready
      do_reset();
      chk("reset we", {31'b0, fetch_we}, 32'h0);
      chk("reset dat_o", fetch_dat_out, 32'h0);
      chk("reset instr", instr, 32'h0);
      chk("reset pc", instr_pc, 32'h0);
      chk("reset fault", {31'b0, instr_fault}, 32'h0);
      vecs.push_back(mk(1, 0, 0,    0, 0,    0));
      vecs.push_back(mk(1, 1, 0,    0, 0,    0));
      vecs.push_back(mk(1, 1, 0,    0, 0,    0));
      vecs.push_back(mk(1, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(1, 1, 4,    0, 0,    0));
      vecs.push_back(mk(1, 1, 4,    0, 0,    0));
      vecs.push_back(mk(1, 0, 0,    1, 'h22, 4));
      vecs.push_back(mk(1, 1, 8,    0, 0,    0));
      vecs.push_back(mk(1, 1, 8,    0, 0,    0));
      vecs.push_back(mk(1, 0, 0,    1, 'h33, 8));
      vecs.push_back(mk(1, 1, 'hC,  0, 0,    0));
      run_vecs("seq");

      // Backpressure: fill to depth, then one pop lets one more fetch out
      do_reset();
      vecs.push_back(mk(0, 0, 0,    0, 0,    0));
      vecs.push_back(mk(0, 1, 0,    0, 0,    0));
      vecs.push_back(mk(0, 1, 0,    0, 0,    0));
      vecs.push_back(mk(0, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(0, 1, 4,    1, 'h11, 0));
      vecs.push_back(mk(0, 1, 4,    1, 'h11, 0));
      vecs.push_back(mk(0, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(0, 1, 8,    1, 'h11, 0));
      vecs.push_back(mk(0, 1, 8,    1, 'h11, 0));
      vecs.push_back(mk(0, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(0, 1, 'hC,  1, 'h11, 0));
      vecs.push_back(mk(0, 1, 'hC,  1, 'h11, 0));
      vecs.push_back(mk(0, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(0, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(0, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(1, 0, 0,    1, 'h11, 0));
      vecs.push_back(mk(0, 1, 'h10, 1, 'h22, 4));
      vecs.push_back(mk(0, 1, 'h10, 1, 'h22, 4));
      vecs.push_back(mk(0, 0, 0,    1, 'h22, 4));
      vecs.push_back(mk(0, 0, 0,    1, 'h22, 4));
      vecs.push_back(mk(0, 0, 0,    1, 'h22, 4));
      run_vecs("bp");

      // Redirect while a request is outstanding
      do_reset();
      wait_stb(32'h0, "rd first adr");
      wait_stb(32'h4, "rd second adr");
      stall = 1'b1;
      @(negedge clk);
      chk("rd stb held", {31'b0, fetch_stb}, 32'h1);
      chk("rd adr held", fetch_adr, 32'h4);
      redirect    = 1'b1;
      redirect_pc = 32'h42;
      stall       = 1'b0;
      @(negedge clk);
      redirect = 1'b0;
      chk("rd flushed", {31'b0, instr_valid}, 32'h0);
      chk("rd stale adr held", fetch_adr, 32'h4);
      @(negedge clk);
      chk("rd gap stb", {31'b0, fetch_stb}, 32'h0);
      chk("rd stale dropped", {31'b0, instr_valid}, 32'h0);
      wait_stb(32'h40, "rd new adr");
      wait_valid("rd deliver");
      chk("rd pc", instr_pc, 32'h40);
      chk("rd instr", instr, 32'hC0DE_0040);
      chk("rd fault", {31'b0, instr_fault}, 32'h0);

      // Bus error halts fetch; redirect resumes
      do_reset();
      pulse_redirect(32'h1FC);
      wait_stb(32'h1FC, "err adr");
      wait_valid("err deliver");
      chk("err pc", instr_pc, 32'h1FC);
      chk("err instr", instr, 32'h0);
      chk("err fault", {31'b0, instr_fault}, 32'h1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (fetch_stb) seen++;
      end
      chk("err halted stb count", seen, 32'h0);
      chk("err entry kept", {31'b0, instr_valid}, 32'h1);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      chk("err popped", {31'b0, instr_valid}, 32'h0);
      pulse_redirect(32'h0);
      wait_stb(32'h0, "err resume adr");
      wait_valid("err resume deliver");
      chk("err resume instr", instr, 32'h11);
      chk("err resume pc", instr_pc, 32'h0);
      chk("err resume fault", {31'b0, instr_fault}, 32'h0);

      // PC wraps at the top of the address space; low bits of target ignored
      do_reset();
      pulse_redirect(32'hFFFF_FFFF);
      wait_stb(32'hFFFF_FFFC, "wrap top adr");
      wait_valid("wrap deliver");
      chk("wrap pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap instr", instr, 32'h3F21_FFFC);
      wait_stb(32'h0, "wrap next adr");

      // Reset during an outstanding request
      do_reset();
      wait_stb(32'h0, "rst first adr");
      wait_stb(32'h4, "rst second adr");
      rst = 1'b1;
      @(negedge clk);
      chk("rst stb drop", {31'b0, fetch_stb}, 32'h0);
      chk("rst valid drop", {31'b0, instr_valid}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst ack ignored", {31'b0, instr_valid}, 32'h0);
      chk("rst restart stb", {31'b0, fetch_stb}, 32'h1);
      chk("rst restart adr", fetch_adr, 32'h0);
      wait_valid("rst deliver");
      chk("rst head pc", instr_pc, 32'h0);
      chk("rst head instr", instr, 32'h11);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      wait_valid("rst second deliver");
      chk("rst second pc", instr_pc, 32'h4);
      chk("rst second instr", instr, 32'h22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
